axi_stream_header_arbiter: RTL
==============================

Name: axi_stream_header_arbiter

Overview:
- Round-robin scheduler sharing one header-insert datapath between NUM_SRC independent sources; each source presents a header (insert channel) plus an AXI-Stream packet.
- Grants one source at a time and routes its header and data channels to the inserter.
- Holds the grant until the inserter's output emits the packet's last beat, so packets never interleave.

Parameters:
- DATA_WD, 32, stream/header data width in bits.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat (keep width).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.
- NUM_SRC, 4, number of requesting sources (2..16).
- SRC_ID_WD, $clog2(NUM_SRC), width of grant_id.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- s_valid_in  in  NUM_SRC  per-source data valid.
- s_data_in  in  NUM_SRC*DATA_WD  per-source data; source i at [i*DATA_WD +: DATA_WD].
- s_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source keep.
- s_last_in  in  NUM_SRC  per-source last.
- s_ready_in  out  NUM_SRC  per-source data ready.
- s_valid_insert  in  NUM_SRC  per-source header valid; also the arbitration request.
- s_data_insert  in  NUM_SRC*DATA_WD  per-source header.
- s_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep.
- s_byte_insert_cnt  in  NUM_SRC*BYTE_CNT_WD  per-source header byte count.
- s_ready_insert  out  NUM_SRC  per-source header ready.
- m_valid_in / m_data_in / m_keep_in / m_last_in  out  1/DATA_WD/DATA_BYTE_WD/1  data channel to the inserter.
- m_ready_in  in  1  inserter data ready.
- m_valid_insert / m_data_insert / m_keep_insert / m_byte_insert_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD  header channel to the inserter.
- m_ready_insert  in  1  inserter header ready.
- mon_valid_out, mon_ready_out, mon_last_out  in  1 each  tap on the inserter output handshake.
- grant_id  out  SRC_ID_WD  currently granted source.
- busy  out  1  high in any state other than IDLE.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; rr_ptr=NUM_SRC-1, so source 0 has first priority.
  - grant_id=0; busy=0; proto_err=0.
  - All s_ready_*, m_valid_* and m_last_in are 0.
  - Reset mid-packet aborts silently; no beat is replayed.
- Non-granted sources always see s_ready_in=s_ready_insert=0.
- m_data_* and m_keep_* = the granted source's fields when the matching m_valid is 1, otherwise 0.
- FSM states: IDLE, HDR, DATA, DRAIN.
- IDLE:
  - Scan s_valid_insert starting at rr_ptr+1 and wrapping modulo NUM_SRC; the first set bit wins.
  - On a win: register grant_id, go to HDR next cycle. No request: stay in IDLE.
  - Nothing is forwarded in IDLE.
- HDR:
  - m_valid_insert = s_valid_insert[g]; s_ready_insert[g] = m_ready_insert; data channel blocked (m_valid_in=0, s_ready_in=0).
  - On m_valid_insert && m_ready_insert, go to DATA.
  - If the granted source drops its valid, the grant is held anyway (no re-arbitration).
- DATA:
  - m_valid_in = s_valid_in[g]; s_ready_in[g] = m_ready_in; m_last_in = s_last_in[g] && s_valid_in[g].
  - Header channel is blocked.
  - On a handshake with last: go to DRAIN; a same-cycle mon last handshake goes straight to IDLE.
- DRAIN:
  - Both channels blocked.
  - On mon_valid_out && mon_ready_out && mon_last_out: set rr_ptr=grant_id and go to IDLE.
- proto_err sets when a mon last handshake occurs in IDLE, HDR, or in DATA without a same-cycle input last handshake. The FSM is unaffected; only reset clears the flag.
- Latency:
  - Request seen at cycle t gives m_valid_insert at t+1.
  - After a packet completes, the next grant costs exactly one IDLE cycle.
  - Ready/valid pass-through within HDR and DATA is combinational; the block adds no registers in the data path.
- A source raising s_valid_insert while another packet is in flight waits; its request is never lost or reordered beyond round-robin order.
- Only state, grant_id, rr_ptr and proto_err are registered.

Test Plan:
- Single source: src1 header 0xA1B2C3D4 (byte_insert_cnt=1), 3 beats, last keep=4'b1100, then mon last -> grant_id=1; header, then 3 beats forwarded unchanged with m_last_in on beat 3; busy drops one cycle after mon last.
- Contention: all 4 sources request at reset release -> grants in order 0,1,2,3,0; each grant waits for its own mon last.
- Starvation check: src0 re-requests immediately after each packet while src2 is pending -> src2 is granted right after src0's packet; src0 is not granted twice in a row.
- Backpressure: m_ready_in toggles 1,0,0,1 during DATA -> s_ready_in[g] mirrors it; no beat lost or duplicated (scoreboard on data values).
- Same-cycle completion: input last handshake and mon last coincide in DATA -> state goes to IDLE directly; proto_err stays 0.
- Mid-packet reset: rst_n low during DATA beat 2 -> all outputs 0 immediately. After release, with src2 and src3 requesting, src2 is granted (reset pointer favours the lowest index).

Source files
------------

// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter: round-robin sharing of one header-insert
// datapath between NUM_SRC sources. The grant is held from header
// acceptance until the inserter output reports the packet's last beat.
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst_n,

  input  logic [NUM_SRC-1:0]                s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
  input  logic [NUM_SRC-1:0]                s_last_in,
  output logic [NUM_SRC-1:0]                s_ready_in,

  input  logic [NUM_SRC-1:0]                s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    s_byte_insert_cnt,
  output logic [NUM_SRC-1:0]                s_ready_insert,

  output logic                              m_valid_in,
  output logic [DATA_WD-1:0]                m_data_in,
  output logic [DATA_BYTE_WD-1:0]           m_keep_in,
  output logic                              m_last_in,
  input  logic                              m_ready_in,

  output logic                              m_valid_insert,
  output logic [DATA_WD-1:0]                m_data_insert,
  output logic [DATA_BYTE_WD-1:0]           m_keep_insert,
  output logic [BYTE_CNT_WD-1:0]            m_byte_insert_cnt,
  input  logic                              m_ready_insert,

  input  logic                              mon_valid_out,
  input  logic                              mon_ready_out,
  input  logic                              mon_last_out,

  output logic [SRC_ID_WD-1:0]              grant_id,
  output logic                              busy,
  output logic                              proto_err
);

  localparam int unsigned NSRC = NUM_SRC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SRC_ID_WD-1:0]   grant_q, grant_d;
  logic [SRC_ID_WD-1:0]   rr_ptr_q, rr_ptr_d;
  logic                   proto_err_q, proto_err_d;

  logic [DATA_WD-1:0]      src_data     [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] src_keep     [NUM_SRC];
  logic [DATA_WD-1:0]      src_hdr      [NUM_SRC];
  logic [DATA_BYTE_WD-1:0] src_hdr_keep [NUM_SRC];
  logic [BYTE_CNT_WD-1:0]  src_hdr_cnt  [NUM_SRC];

  logic                   req_found;
  logic [SRC_ID_WD-1:0]   req_idx;
  logic [SRC_ID_WD-1:0]   cand;
  logic                   mon_last_hs;
  logic                   in_last_hs;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign src_data[gi]     = s_data_in[gi*DATA_WD +: DATA_WD];
    assign src_keep[gi]     = s_keep_in[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign src_hdr[gi]      = s_data_insert[gi*DATA_WD +: DATA_WD];
    assign src_hdr_keep[gi] = s_keep_insert[gi*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign src_hdr_cnt[gi]  = s_byte_insert_cnt[gi*BYTE_CNT_WD +: BYTE_CNT_WD];
  end

  // Scan starts one past the last completed source so it ends up last in line.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NSRC; k++) begin
      cand = SRC_ID_WD'((32'(rr_ptr_q) + k) % NSRC);
      if (!req_found && s_valid_insert[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  always_comb begin
    s_ready_in        = '0;
    s_ready_insert    = '0;
    m_valid_in        = 1'b0;
    m_data_in         = '0;
    m_keep_in         = '0;
    m_last_in         = 1'b0;
    m_valid_insert    = 1'b0;
    m_data_insert     = '0;
    m_keep_insert     = '0;
    m_byte_insert_cnt = '0;
    unique case (state_q)
      HDR: begin
        m_valid_insert          = s_valid_insert[grant_q];
        s_ready_insert[grant_q] = m_ready_insert;
      end
      DATA: begin
        m_valid_in          = s_valid_in[grant_q];
        s_ready_in[grant_q] = m_ready_in;
        m_last_in           = s_last_in[grant_q] & s_valid_in[grant_q];
      end
      default: ;
    endcase
    if (m_valid_insert) begin
      m_data_insert     = src_hdr[grant_q];
      m_keep_insert     = src_hdr_keep[grant_q];
      m_byte_insert_cnt = src_hdr_cnt[grant_q];
    end
    if (m_valid_in) begin
      m_data_in = src_data[grant_q];
      m_keep_in = src_keep[grant_q];
    end
  end

  assign mon_last_hs = mon_valid_out & mon_ready_out & mon_last_out;
  assign in_last_hs  = m_valid_in & m_ready_in & m_last_in;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      IDLE: begin
        if (mon_last_hs) proto_err_d = 1'b1;
        if (req_found) begin
          state_d = HDR;
          grant_d = req_idx;
        end
      end
      HDR: begin
        if (mon_last_hs) proto_err_d = 1'b1;
        if (m_valid_insert && m_ready_insert) state_d = DATA;
      end
      DATA: begin
        if (in_last_hs) begin
          if (mon_last_hs) begin
            state_d  = IDLE;
            rr_ptr_d = grant_q;
          end else begin
            state_d = DRAIN;
          end
        end else if (mon_last_hs) begin
          proto_err_d = 1'b1;
        end
      end
      DRAIN: begin
        if (mon_last_hs) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= SRC_ID_WD'(NUM_SRC - 1);
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = proto_err_q;

endmodule
